// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the N-channel round-robin mutex arbiter.
package arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Round-robin successor of a channel index, wrapping from n-1 back to 0.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the eligible vector so ptr sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   elig,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] win_id
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_off;
    logic           w_found;
    logic [IDW:0]   w_sum;
    logic [IDW:0]   w_wrap;

    assign w_dbl = {elig, elig};
    assign w_rot = w_dbl[int'(ptr) +: N];

    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = IDW'(k);
            end
        end
    end

    assign w_sum  = {1'b0, ptr} + {1'b0, w_off};
    assign w_wrap = w_sum - (IDW+1)'(N);

    always_comb begin
        win_id = '0;
        win    = '0;
        if (w_found) begin
            win_id = (w_sum >= (IDW+1)'(N)) ? w_wrap[IDW-1:0] : w_sum[IDW-1:0];
            win    = N'(1) << win_id;
        end
    end

endmodule

// File: rtl/arbiter_n_mutex.sv
// N-channel mutex: round-robin grant, held until release, one-cycle dead gap,
// optional hold timeout that revokes and locks a stuck owner.
//   state   | meaning
//   ST_IDLE | no grant, arbitrate every cycle
//   ST_OWN  | exactly one grant bit high, owner in r_grant_id
//   ST_GAP  | single dead cycle between owners, arbitrate for the next one
module arbiter_n_mutex
    import arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 0,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout
);

    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] HOLD_TC  = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [CW-1:0] HOLD_SAT = CW'(HOLD_MAX);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   w_grant_nxt;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] w_grant_id_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_nxt;
    logic [N-1:0]   r_lock;
    logic [N-1:0]   w_lock_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           r_timeout;
    logic           w_timeout_nxt;

    logic [N-1:0]   w_elig;
    logic [N-1:0]   w_win;
    logic [IDW-1:0] w_win_id;

    assign w_elig = req & ~r_lock;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .elig   (w_elig),
        .ptr    (r_ptr),
        .win    (w_win),
        .win_id (w_win_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_lock     <= '0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock     <= w_lock_nxt;
            r_cnt      <= w_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        // A lock survives only while its request stays high.
        w_lock_nxt     = r_lock & req;
        w_cnt_nxt      = r_cnt;
        w_timeout_nxt  = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (|w_elig) begin
                    w_state_nxt    = ST_OWN;
                    w_grant_nxt    = w_win;
                    w_grant_id_nxt = w_win_id;
                    w_ptr_nxt      = IDW'(rr_next(int'(w_win_id), N));
                    w_cnt_nxt      = '0;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                end
            end
            ST_OWN: begin
                // Release is tested first so a coincident timeout is a plain release.
                if (!req[r_grant_id]) begin
                    w_state_nxt    = ST_GAP;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                end else if ((HOLD_MAX > 0) && (r_cnt == HOLD_TC)) begin
                    w_state_nxt              = ST_GAP;
                    w_grant_nxt              = '0;
                    w_grant_id_nxt           = '0;
                    w_timeout_nxt            = 1'b1;
                    w_lock_nxt[r_grant_id]   = 1'b1;
                end else if (r_cnt != HOLD_SAT) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
            end
        endcase
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = |r_grant;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_arbiter_n_mutex.sv
// Scoreboard bench for arbiter_n_mutex (N=4, HOLD_MAX=8) against a cycle-level
// behavioural model of the mutex rules.
module tb_arbiter_n_mutex;

    localparam int N    = 4;
    localparam int HOLD = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    arbiter_n_mutex #(.N(N), .HOLD_MAX(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       to;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model: who owns the resource, for how many cycles, RR pointer, locks.
    int   m_owner;
    int   m_held;
    int   m_ptr;
    bit   m_lock[N];
    bit   m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 0;
        for (int i = 0; i < N; i++) m_lock[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 0;
        for (int i = 0; i < N; i++) if (!r[i]) m_lock[i] = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (m_held == HOLD) begin
                m_lock[m_owner] = 1;
                m_owner = -1;
                m_to    = 1;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && r[idx] && !m_lock[idx]) begin
                    m_owner = idx;
                    m_held  = 1;
                    m_ptr   = (idx + 1) % N;
                end
            end
        end
    endtask

    task automatic cycle(input logic [3:0] r);
        exp_t e;
        req = r;
        @(posedge clk);
        model_step(r);
        e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.b  = (m_owner >= 0);
        e.to = m_to;
        q.push_back(e);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"},   32'(grant),    0);
        chk({tag, "_id"},      32'(grant_id), 0);
        chk({tag, "_busy"},    32'(busy),     0);
        chk({tag, "_timeout"}, 32'(timeout),  0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot0", 32'($onehot0(grant)), 1);
            if (q.size() > 0) begin
                e_mon = q.pop_front();
                chk("grant",    32'(grant),    32'(e_mon.g));
                chk("grant_id", 32'(grant_id), 32'(e_mon.id));
                chk("busy",     32'(busy),     32'(e_mon.b));
                chk("timeout",  32'(timeout),  32'(e_mon.to));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_zero("reset");
        #19 rst_n = 1'b1;

        // Basic grant, release, gap, next grant.
        cycle(4'b0101); cycle(4'b0101);
        cycle(4'b0100); cycle(4'b0100); cycle(4'b0100);
        cycle(4'b0000); cycle(4'b0000);

        // All requesting; owner drops for one cycle and re-raises.
        cycle(4'b1111);
        for (int h = 0; h < 5; h++) begin
            repeat (2) cycle(4'b1111);
            r = 4'b1111;
            if (m_owner >= 0) r[m_owner] = 1'b0;
            cycle(r);
            cycle(4'b1111);
        end
        repeat (2) cycle(4'b0000);

        // Steer pointer to 3, then 3 and 0 compete: wrap-around.
        repeat (2) cycle(4'b0100);
        repeat (2) cycle(4'b0000);
        repeat (3) cycle(4'b1001);
        repeat (3) cycle(4'b0001);
        repeat (2) cycle(4'b0000);

        // Stuck owner: timeout, lock, other channel granted, relock until toggle.
        for (int i = 0; i < 14; i++) cycle(i >= 5 ? 4'b1100 : 4'b0100);
        repeat (3) cycle(4'b0100);
        cycle(4'b0000);
        repeat (2) cycle(4'b0100);
        repeat (2) cycle(4'b0000);

        // Release coincides with the timeout edge: plain release, no lock.
        repeat (8) cycle(4'b0010);
        cycle(4'b0000);
        repeat (2) cycle(4'b0010);
        repeat (2) cycle(4'b0000);

        // Random traffic; owners tend to hold long enough to hit timeouts.
        r = 4'b0000;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner == i) r[i] = ($urandom_range(0, 9) != 0);
                else if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
            end
            cycle(r);
        end
        repeat (2) cycle(4'b0000);

        // Asynchronous reset in the middle of an ownership.
        repeat (3) cycle(4'b0100);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        q.delete();
        model_reset();
        req = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #4 rst_n = 1'b1;
        repeat (2) cycle(4'b1001);
        repeat (2) cycle(4'b0000);
        repeat (2) cycle(4'b0010);
        repeat (2) cycle(4'b0000);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
